// File: rtl/des_round_ctrl_if.sv
// des_round_ctrl_if: handshake and f-function bus of the DES round controller.
interface des_round_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_lr;
   logic        decrypt;
   logic [31:0] f_r;
   logic [3:0]  f_round;
   logic [31:0] f_out;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_rl;
   logic        busy;
   modport master (
      output in_valid, in_lr, decrypt, f_out, out_ready,
      input  in_ready, f_r, f_round, out_valid, out_rl, busy
   );
   modport slave (
      input  in_valid, in_lr, decrypt, f_out, out_ready,
      output in_ready, f_r, f_round, out_valid, out_rl, busy
   );
endinterface

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative 16-round DES Feistel controller holding the L/R halves.
// Macro DES_DECRYPT_EN enables reversed subkey order when decrypt is latched high.
module des_round_ctrl (
   input logic             clk,
   input logic             rst_n,
   des_round_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state, state_nx;
   logic [31:0] l, r;
   logic [3:0]  cnt;
   logic        dec;
   logic        load;
   assign load = (state == IDLE) && bus.in_valid;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = load ? RUN :
                 (state == RUN && cnt == 4'd15) ? DONE :
                 (state == DONE && bus.out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         l   <= '0;
         r   <= '0;
         cnt <= '0;
      end else if (load) begin
         l   <= bus.in_lr[63:32];
         r   <= bus.in_lr[31:0];
         cnt <= '0;
      end else if (state == RUN) begin
         l   <= r;
         r   <= l ^ bus.f_out;
         cnt <= cnt + 4'd1;
      end
`ifdef DES_DECRYPT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dec <= 1'b0;
      else if (load) dec <= bus.decrypt;
`else
   logic unused_decrypt;
   assign unused_decrypt = bus.decrypt;
   assign dec = 1'b0;
`endif
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.f_r       = r;
   // decryption walks the subkeys backwards: 15-cnt is just ~cnt in 4 bits
   assign bus.f_round   = (state == RUN) ? (dec ? ~cnt : cnt) : 4'd0;
   assign bus.out_rl    = (state == DONE) ? {r, l} : 64'd0;
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: random and directed checks of des_round_ctrl against a Feistel model.
module tb_des_round_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int s_cmp = 0, s_bad = 0, m_cmp = 0, m_bad = 0;
   int cyc = 0;
   int fsel = 0;
   logic [31:0] key [16];
`ifdef DES_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif
   des_round_ctrl_if bus();
   des_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   function automatic logic [31:0] fmod(int sel, logic [31:0] r, logic [3:0] k);
      if (sel == 1) return (k == 4'd0) ? 32'h1 : 32'h0;
      if (sel == 2) return {r[26:0], r[31:27]} ^ key[k] ^ {28'h0, k};
      return 32'h0;
   endfunction
   always_comb bus.f_out = fmod(fsel, bus.f_r, bus.f_round);
   function automatic logic [3:0] ridx(logic d, int i);
      return d ? 4'(15 - i) : 4'(i);
   endfunction
   function automatic logic [63:0] ref_out(logic [63:0] lr, logic d);
      logic [31:0] l, r, t;
      l = lr[63:32];
      r = lr[31:0];
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ fmod(fsel, r, ridx(d & DEC_EN, i));
         l = t;
      end
      return {r, l};
   endfunction
   function automatic bit bad(string name, logic [63:0] act, logic [63:0] exp);
      if (act !== exp) $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      return act !== exp;
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      s_cmp++;
      s_bad += int'(bad(name, act, exp));
   endtask
   task automatic mchk(string name, logic [63:0] act, logic [63:0] exp);
      m_cmp++;
      m_bad += int'(bad(name, act, exp));
   endtask
   // cycle model: phase -1 idle, 0..15 round in progress, 16 result waiting
   int phase = -1;
   logic m_dec = 1'b0;
   logic [31:0] last_r = '0;
   logic [31:0] m_l [17];
   logic [31:0] m_r [17];
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase = -1;
         last_r = '0;
      end else begin
         mchk("in_ready", 64'(bus.in_ready), 64'(phase < 0));
         mchk("out_valid", 64'(bus.out_valid), 64'(phase == 16));
         mchk("busy", 64'(bus.busy), 64'(phase >= 0));
         mchk("f_round", 64'(bus.f_round), (phase >= 0 && phase < 16) ? 64'(ridx(m_dec, phase)) : 64'd0);
         mchk("f_r", 64'(bus.f_r), phase < 0 ? 64'(last_r) : 64'(m_r[phase]));
         if (phase == 16) mchk("out_rl", bus.out_rl, {m_r[16], m_l[16]});
         if (phase < 0) begin
            if (bus.in_valid) begin
               m_dec = bus.decrypt & DEC_EN;
               m_l[0] = bus.in_lr[63:32];
               m_r[0] = bus.in_lr[31:0];
               for (int i = 0; i < 16; i++) begin
                  m_l[i+1] = m_r[i];
                  m_r[i+1] = m_l[i] ^ fmod(fsel, m_r[i], ridx(m_dec, i));
               end
               phase = 0;
            end
         end else if (phase < 16) phase++;
         else if (bus.out_ready) begin
            last_r = m_r[16];
            phase = -1;
         end
      end
   end
   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(logic [63:0] lr, logic d, output int lat);
      bus.in_lr = lr;
      bus.decrypt = d;
      bus.in_valid = 1'b1;
      step(1);
      bus.in_valid = 1'b0;
      bus.in_lr = {$urandom, $urandom};
      bus.decrypt = ~d;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         step(1);
         lat++;
      end
   endtask
   task automatic order_chk(logic d);
      bus.in_lr = {$urandom, $urandom};
      bus.decrypt = d;
      bus.in_valid = 1'b1;
      step(1);
      bus.in_valid = 1'b0;
      bus.decrypt = ~d;
      for (int i = 0; i < 16; i++) begin
         chk(d ? "order_dec" : "order_enc", 64'(bus.f_round), 64'(ridx(d & DEC_EN, i)));
         step(1);
      end
      chk("order_done", 64'(bus.out_valid), 64'd1);
      step(1);
   endtask
   initial begin
      int lat, seen, last_rise;
      logic [63:0] lr, exp;
      logic d;
      logic prev;
      for (int i = 0; i < 16; i++) key[i] = $urandom;
      bus.in_valid = 1'b0;
      bus.in_lr = '0;
      bus.decrypt = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_out_rl", bus.out_rl, 64'd0);
      chk("rst_f_round", 64'(bus.f_round), 64'd0);
      chk("rst_f_r", 64'(bus.f_r), 64'd0);
      #10 rst_n = 1'b1;
      step(1);
      bus.out_ready = 1'b1;
      send(64'h01234567_89ABCDEF, 1'b0, lat);
      chk("zero_f_latency", 64'(lat), 64'd16);
      chk("zero_f_out", bus.out_rl, 64'h89ABCDEF_01234567);
      step(1);
      fsel = 1;
      send(64'h01234567_89ABCDEF, 1'b0, lat);
      chk("inject_latency", 64'(lat), 64'd16);
      chk("inject_out", bus.out_rl, 64'h89ABCDEF_01234566);
      step(1);
      fsel = 2;
      order_chk(1'b1);
      order_chk(1'b0);
      bus.out_ready = 1'b0;
      lr = {$urandom, $urandom};
      d = 1'($urandom);
      exp = ref_out(lr, d);
      send(lr, d, lat);
      chk("bp_latency", 64'(lat), 64'd16);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = (i == 3);
         bus.in_lr = {$urandom, $urandom};
         chk("bp_out_rl", bus.out_rl, exp);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         step(1);
      end
      bus.in_valid = 1'b0;
      chk("bp_still_valid", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      step(1);
      chk("bp_release_idle", 64'(bus.in_ready), 64'd1);
      chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
      bus.in_valid = 1'b1;
      prev = 1'b0;
      last_rise = -1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         bus.in_lr = {$urandom, $urandom};
         if (bus.out_valid && !prev) begin
            if (last_rise >= 0) chk("b2b_interval", 64'(cyc - last_rise), 64'd18);
            last_rise = cyc;
            seen++;
         end
         prev = bus.out_valid;
         step(1);
      end
      chk("b2b_blocks", 64'(seen >= 3), 64'd1);
      bus.in_valid = 1'b0;
      step(20);
      bus.in_lr = {$urandom, $urandom};
      bus.in_valid = 1'b1;
      step(1);
      bus.in_valid = 1'b0;
      step(7);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_out_rl", bus.out_rl, 64'd0);
      chk("abort_f_round", 64'(bus.f_round), 64'd0);
      step(2);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.out_valid) seen++;
      end
      chk("abort_no_output", 64'(seen), 64'd0);
      lr = {$urandom, $urandom};
      d = 1'($urandom);
      exp = ref_out(lr, d);
      send(lr, d, lat);
      chk("after_abort_latency", 64'(lat), 64'd16);
      chk("after_abort_out", bus.out_rl, exp);
      step(1);
      for (int i = 0; i < 1500; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_lr = {$urandom, $urandom};
         bus.decrypt = 1'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", s_cmp + m_cmp, s_bad + m_bad);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
